// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe requester-request path: default stream widths,
// the beat record carried through the output register slice, and the arbiter states.
package pcie_pkg;

    localparam int PCIE_DATA_WIDTH_DEFAULT = 64;
    localparam int PCIE_KEEP_WIDTH_DEFAULT = PCIE_DATA_WIDTH_DEFAULT / 32;
    localparam int TUSER_WIDTH_DEFAULT     = 85;

    // One RQ beat; field order fixes the packed layout used by the slice.
    typedef struct packed {
        logic [PCIE_DATA_WIDTH_DEFAULT-1:0] data;
        logic [TUSER_WIDTH_DEFAULT-1:0]     tuser;
        logic [PCIE_KEEP_WIDTH_DEFAULT-1:0] tkeep;
        logic                               tlast;
    } rq_beat_t;

    localparam int RQ_BEAT_W = $bits(rq_beat_t);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    // Successor of a requester index in the rotating order, wrapping to 0.
    function automatic int next_index(input int idx, input int num);
        return (idx >= num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pcie_axis_skid.sv
// Two-entry AXI-Stream register slice. The output always comes from the head
// register, and the input ready depends only on the fill count, so no combinational
// path runs from the downstream ready back to the upstream side.
module pcie_axis_skid
    import pcie_pkg::*;
#(
    parameter int WIDTH = RQ_BEAT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Fill/drain bookkeeping: head is what the core sees, tail catches one extra beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        tail  <= in_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
                default: begin
                    count <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Packet-atomic round-robin arbiter sharing the PCIe RQ stream between NUM_REQ
// request engines. A grant covers one whole TLP; the next winner is chosen only
// after tlast, starting the search just past the previous winner.
module pcie_rq_arbiter
    import pcie_pkg::*;
#(
    parameter int PCIE_DATA_WIDTH = PCIE_DATA_WIDTH_DEFAULT,
    parameter int PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH / 32,
    parameter int TUSER_WIDTH     = TUSER_WIDTH_DEFAULT,
    parameter int NUM_REQ         = 4,
    parameter int REQ_IDX_W       = $clog2(NUM_REQ)
)(
    input  logic                               pcie_clk_in,
    input  logic                               pcie_reset_out,
    input  logic                               pcie_link_up,
    input  logic [NUM_REQ*PCIE_DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ*TUSER_WIDTH-1:0]     req_tuser,
    input  logic [NUM_REQ*PCIE_KEEP_WIDTH-1:0] req_tkeep,
    input  logic [NUM_REQ-1:0]                 req_tlast,
    input  logic [NUM_REQ-1:0]                 req_tvalid,
    output logic [NUM_REQ-1:0]                 req_tready,
    output logic [PCIE_DATA_WIDTH-1:0]         s_axis_rq_tdata,
    output logic [TUSER_WIDTH-1:0]             s_axis_rq_tuser,
    output logic [PCIE_KEEP_WIDTH-1:0]         s_axis_rq_tkeep,
    output logic                               s_axis_rq_tlast,
    output logic                               s_axis_rq_tvalid,
    input  logic                               s_axis_rq_tready,
    output logic [REQ_IDX_W-1:0]               grant_idx,
    output logic                               busy
);

    // Same field order as rq_beat_t, sized from this instance's parameters.
    localparam int BEAT_W = PCIE_DATA_WIDTH + TUSER_WIDTH + PCIE_KEEP_WIDTH + 1;

    arb_state_e                 state;
    logic [REQ_IDX_W-1:0]       rr_ptr;
    logic [REQ_IDX_W-1:0]       next_grant;
    logic                       any_req;

    logic [PCIE_DATA_WIDTH-1:0] sel_tdata;
    logic [TUSER_WIDTH-1:0]     sel_tuser;
    logic [PCIE_KEEP_WIDTH-1:0] sel_tkeep;
    logic                       sel_tlast;
    logic                       sel_tvalid;

    logic                       skid_in_valid;
    logic                       skid_in_ready;
    logic [BEAT_W-1:0]          skid_in_data;
    logic [BEAT_W-1:0]          skid_out_data;
    logic                       accept;

    assign any_req = |req_tvalid;

    // Rotating priority search: walk from rr_ptr upward; the lowest offset that is valid wins.
    always_comb begin
        logic [REQ_IDX_W:0] cand;
        next_grant = rr_ptr;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (REQ_IDX_W + 1)'(k);
            if (cand >= (REQ_IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (REQ_IDX_W + 1)'(NUM_REQ);
            end
            if (req_tvalid[cand[REQ_IDX_W-1:0]]) begin
                next_grant = cand[REQ_IDX_W-1:0];
            end
        end
    end

    // Grant mux: pick the granted requester's beat from the packed input buses.
    always_comb begin
        sel_tdata  = '0;
        sel_tuser  = '0;
        sel_tkeep  = '0;
        sel_tlast  = 1'b0;
        sel_tvalid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == REQ_IDX_W'(i)) begin
                sel_tdata  = req_tdata[i*PCIE_DATA_WIDTH +: PCIE_DATA_WIDTH];
                sel_tuser  = req_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
                sel_tkeep  = req_tkeep[i*PCIE_KEEP_WIDTH +: PCIE_KEEP_WIDTH];
                sel_tlast  = req_tlast[i];
                sel_tvalid = req_tvalid[i];
            end
        end
    end

    // Ready demux: only the granted requester sees the slice's ready, and only while transferring.
    always_comb begin
        req_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state == ARB_XFER) && (grant_idx == REQ_IDX_W'(i))) begin
                req_tready[i] = skid_in_ready;
            end
        end
    end

    assign skid_in_valid = (state == ARB_XFER) && sel_tvalid;
    assign accept        = skid_in_valid && skid_in_ready;
    assign skid_in_data  = {sel_tdata, sel_tuser, sel_tkeep, sel_tlast};

    // Arbitration FSM: a new grant needs the link up; an open packet always runs to tlast.
    always_ff @(posedge pcie_clk_in or posedge pcie_reset_out) begin
        if (pcie_reset_out) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pcie_link_up && any_req) begin
                        grant_idx <= next_grant;
                        busy      <= 1'b1;
                        state     <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if (accept && sel_tlast) begin
                        rr_ptr <= REQ_IDX_W'(next_index(int'(grant_idx), NUM_REQ));
                        busy   <= 1'b0;
                        state  <= ARB_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    pcie_axis_skid #(
        .WIDTH (BEAT_W)
    ) rq_skid (
        .clk       (pcie_clk_in),
        .rst       (pcie_reset_out),
        .in_data   (skid_in_data),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (s_axis_rq_tvalid),
        .out_ready (s_axis_rq_tready)
    );

    assign {s_axis_rq_tdata, s_axis_rq_tuser, s_axis_rq_tkeep, s_axis_rq_tlast} = skid_out_data;

endmodule
